// File: rtl/vtpg_pkg.sv
// vtpg_pkg: shared types for the video timing / test-pattern generator.
//   vtpg_mode_e : pattern select encoding (codes 5..7 fall back to SOLID)
//   BAR_*       : {R,G,B} on/off bits for the eight colour bars
//   bar_rgb()   : bar index -> {R,G,B} bits, white..black
package vtpg_pkg;

  typedef enum logic [2:0] {
    SOLID   = 3'd0,
    HRAMP   = 3'd1,
    BARS    = 3'd2,
    CHECKER = 3'd3,
    MOVING  = 3'd4
  } vtpg_mode_e;

  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  // Classic bar order: B follows ~idx[0], R follows ~idx[1], G follows ~idx[2],
  // which yields white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vtpg_if.sv
// vtpg_if: video output bus of the pattern generator.
//   hs_q, vs_q   : syncs (polarity set by the generator)
//   vld_q        : active pixel
//   sof_q        : start-of-frame pulse with pixel (0,0)
//   rgb          : {R,G,B}, PW bits per channel
//   frame_cnt_q  : completed frame count
// master = generator side, slave = consumer side.
interface vtpg_if #(parameter int PW = 8);
  logic            hs_q;
  logic            vs_q;
  logic            vld_q;
  logic            sof_q;
  logic [3*PW-1:0] rgb;
  logic [7:0]      frame_cnt_q;

  modport master (output hs_q, vs_q, vld_q, sof_q, rgb, frame_cnt_q);
  modport slave  (input  hs_q, vs_q, vld_q, sof_q, rgb, frame_cnt_q);
endinterface

// File: rtl/vtpg_timing.sv
// vtpg_timing: h/v counters, shadowed timing windows and window decode.
//   clk, rst_n      : clock, async active-low reset
//   i_en            : advance counters
//   i_*_start/end   : window registers (half-open), i_h_end / i_v_end last count
//   o_load          : shadow config captures this cycle
//   o_bypass        : first enabled cycle after reset; decode uses live inputs
//   o_hs/o_vs/o_act : combinational window decode of current (h,v)
//   o_sof           : current position is (0,0)
//   o_x, o_y        : position relative to active-window origin
//   o_frame_cnt     : completed frames
module vtpg_timing
  import vtpg_pkg::*;
#(
  parameter int H_BITS = 12,
  parameter int V_BITS = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [H_BITS-1:0] i_hs_start,
  input  logic [H_BITS-1:0] i_hs_end,
  input  logic [H_BITS-1:0] i_hact_start,
  input  logic [H_BITS-1:0] i_hact_end,
  input  logic [H_BITS-1:0] i_h_end,
  input  logic [V_BITS-1:0] i_vs_start,
  input  logic [V_BITS-1:0] i_vs_end,
  input  logic [V_BITS-1:0] i_vact_start,
  input  logic [V_BITS-1:0] i_vact_end,
  input  logic [V_BITS-1:0] i_v_end,
  output logic              o_load,
  output logic              o_bypass,
  output logic              o_hs,
  output logic              o_vs,
  output logic              o_act,
  output logic              o_sof,
  output logic [H_BITS-1:0] o_x,
  output logic [V_BITS-1:0] o_y,
  output logic [7:0]        o_frame_cnt
);

  localparam int CW = 5 * H_BITS + 5 * V_BITS;

  logic              r_started;
  logic [H_BITS-1:0] r_h;
  logic [V_BITS-1:0] r_v;
  logic [7:0]        r_frame_cnt;
  logic [CW-1:0]     r_cfg;

  logic [CW-1:0]     w_cfg_in;
  logic [CW-1:0]     w_cfg;
  logic [H_BITS-1:0] w_hs_start, w_hs_end, w_hact_start, w_hact_end, w_h_end;
  logic [V_BITS-1:0] w_vs_start, w_vs_end, w_vact_start, w_vact_end, w_v_end;
  logic              w_h_last, w_v_last, w_wrap;

  assign w_cfg_in = {i_hs_start, i_hs_end, i_hact_start, i_hact_end, i_h_end,
                     i_vs_start, i_vs_end, i_vact_start, i_vact_end, i_v_end};

  // The very first pixel after reset has no shadow yet, so decode it from
  // the live inputs that are being captured in the same cycle.
  assign w_cfg = o_bypass ? w_cfg_in : r_cfg;

  assign {w_hs_start, w_hs_end, w_hact_start, w_hact_end, w_h_end,
          w_vs_start, w_vs_end, w_vact_start, w_vact_end, w_v_end} = w_cfg;

  assign w_h_last = (r_h == w_h_end);
  assign w_v_last = (r_v == w_v_end);
  assign w_wrap   = w_h_last & w_v_last;

  assign o_bypass = i_en & ~r_started;
  assign o_load   = i_en & (~r_started | w_wrap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started   <= 1'b0;
      r_h         <= '0;
      r_v         <= '0;
      r_frame_cnt <= '0;
      r_cfg       <= '0;
    end else if (i_en) begin
      r_started <= 1'b1;
      if (o_load) r_cfg <= w_cfg_in;
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + V_BITS'(1);
      end else begin
        r_h <= r_h + H_BITS'(1);
      end
      if (w_wrap) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign o_hs  = (r_h >= w_hs_start) && (r_h < w_hs_end);
  assign o_vs  = (r_v >= w_vs_start) && (r_v < w_vs_end);
  assign o_act = (r_h >= w_hact_start) && (r_h < w_hact_end) &&
                 (r_v >= w_vact_start) && (r_v < w_vact_end);
  assign o_sof = (r_h == '0) && (r_v == '0);
  assign o_x   = r_h - w_hact_start;
  assign o_y   = r_v - w_vact_start;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: rtl/vtpg.sv
// vtpg: programmable video timing and test-pattern generator.
//   clk, rst_n            : pixel clock, async active-low reset
//   en                    : advance timing; low freezes counters
//   mode                  : pattern select (vtpg_mode_e), latched per frame
//   solid_rgb             : colour for SOLID
//   chk_shift, bar_shift  : log2 checker square / bar width
//   tHS_*, tHACT_*, tH_END: horizontal windows and line length
//   tVS_*, tVACT_*, tV_END: vertical windows and frame length
//   o_vid                 : video output bus (vtpg_if master)
// All outputs are registered one cycle after the counter position they show.
module vtpg
  import vtpg_pkg::*;
#(
  parameter int   PW       = 8,
  parameter int   H_BITS   = 12,
  parameter int   V_BITS   = 12,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [2:0]        mode,
  input  logic [3*PW-1:0]   solid_rgb,
  input  logic [3:0]        chk_shift,
  input  logic [3:0]        bar_shift,
  input  logic [H_BITS-1:0] tHS_START,
  input  logic [H_BITS-1:0] tHS_END,
  input  logic [H_BITS-1:0] tHACT_START,
  input  logic [H_BITS-1:0] tHACT_END,
  input  logic [H_BITS-1:0] tH_END,
  input  logic [V_BITS-1:0] tVS_START,
  input  logic [V_BITS-1:0] tVS_END,
  input  logic [V_BITS-1:0] tVACT_START,
  input  logic [V_BITS-1:0] tVACT_END,
  input  logic [V_BITS-1:0] tV_END,
  vtpg_if.master            o_vid
);

  logic              w_load, w_bypass;
  logic              w_hs, w_vs, w_act, w_sof;
  logic [H_BITS-1:0] w_x;
  logic [V_BITS-1:0] w_y;
  logic [7:0]        w_frame_cnt;

  vtpg_timing #(.H_BITS(H_BITS), .V_BITS(V_BITS)) u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (en),
    .i_hs_start   (tHS_START),
    .i_hs_end     (tHS_END),
    .i_hact_start (tHACT_START),
    .i_hact_end   (tHACT_END),
    .i_h_end      (tH_END),
    .i_vs_start   (tVS_START),
    .i_vs_end     (tVS_END),
    .i_vact_start (tVACT_START),
    .i_vact_end   (tVACT_END),
    .i_v_end      (tV_END),
    .o_load       (w_load),
    .o_bypass     (w_bypass),
    .o_hs         (w_hs),
    .o_vs         (w_vs),
    .o_act        (w_act),
    .o_sof        (w_sof),
    .o_x          (w_x),
    .o_y          (w_y),
    .o_frame_cnt  (w_frame_cnt)
  );

  logic [2:0]      r_mode;
  logic [3*PW-1:0] r_solid;
  logic [3:0]      r_chk, r_bar;

  logic [2:0]      w_mode;
  logic [3*PW-1:0] w_solid;
  logic [3:0]      w_chk, w_bar;
  logic [2:0]      w_bar_idx, w_bar_c;
  logic            w_x_chk, w_y_chk;
  logic [PW-1:0]   w_mov;
  logic [3*PW-1:0] w_pix;

  logic            r_hs, r_vs, r_vld, r_sof;
  logic [3*PW-1:0] r_rgb;

  assign w_mode  = w_bypass ? mode      : r_mode;
  assign w_solid = w_bypass ? solid_rgb : r_solid;
  assign w_chk   = w_bypass ? chk_shift : r_chk;
  assign w_bar   = w_bypass ? bar_shift : r_bar;

  assign w_bar_idx = 3'(w_x >> w_bar);
  assign w_bar_c   = bar_rgb(w_bar_idx);
  assign w_x_chk   = 1'(w_x >> w_chk);
  assign w_y_chk   = 1'(w_y >> w_chk);
  assign w_mov     = w_x[PW-1:0] + PW'(w_frame_cnt);

  always_comb begin
    w_pix = w_solid;
    case (vtpg_mode_e'(w_mode))
      HRAMP:   w_pix = {3{w_x[PW-1:0]}};
      BARS:    w_pix = {{PW{w_bar_c[2]}}, {PW{w_bar_c[1]}}, {PW{w_bar_c[0]}}};
      CHECKER: w_pix = {(3*PW){w_x_chk ^ w_y_chk}};
      MOVING:  w_pix = {3{w_mov}};
      default: w_pix = w_solid;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= '0;
      r_solid <= '0;
      r_chk   <= '0;
      r_bar   <= '0;
      r_hs    <= ~SYNC_POL;
      r_vs    <= ~SYNC_POL;
      r_vld   <= 1'b0;
      r_sof   <= 1'b0;
      r_rgb   <= '0;
    end else begin
      if (w_load) begin
        r_mode  <= mode;
        r_solid <= solid_rgb;
        r_chk   <= chk_shift;
        r_bar   <= bar_shift;
      end
      if (en) begin
        r_hs  <= w_hs ? SYNC_POL : ~SYNC_POL;
        r_vs  <= w_vs ? SYNC_POL : ~SYNC_POL;
        r_vld <= w_act;
        r_sof <= w_sof;
        r_rgb <= w_act ? w_pix : '0;
      end else begin
        // Syncs keep their level while frozen; pixel qualifiers drop.
        r_vld <= 1'b0;
        r_sof <= 1'b0;
        r_rgb <= '0;
      end
    end
  end

  assign o_vid.hs_q        = r_hs;
  assign o_vid.vs_q        = r_vs;
  assign o_vid.vld_q       = r_vld;
  assign o_vid.sof_q       = r_sof;
  assign o_vid.rgb         = r_rgb;
  assign o_vid.frame_cnt_q = w_frame_cnt;

endmodule

// File: tb/tb_vtpg.sv
module tb_vtpg;
  localparam int PW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  mode;
  logic [23:0] solid_rgb;
  logic [3:0]  chk_shift, bar_shift;
  logic [11:0] tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
  logic [11:0] tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;

  int n_tests = 0;
  int n_fail  = 0;

  vtpg_if #(.PW(PW)) vid ();

  vtpg #(.PW(PW), .H_BITS(12), .V_BITS(12), .SYNC_POL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .chk_shift(chk_shift), .bar_shift(bar_shift),
    .tHS_START(tHS_START), .tHS_END(tHS_END), .tHACT_START(tHACT_START),
    .tHACT_END(tHACT_END), .tH_END(tH_END),
    .tVS_START(tVS_START), .tVS_END(tVS_END), .tVACT_START(tVACT_START),
    .tVACT_END(tVACT_END), .tV_END(tV_END),
    .o_vid(vid)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    int hs_s, hs_e, ha_s, ha_e, h_end;
    int vs_s, vs_e, va_s, va_e, v_end;
    int mode, chk, bar;
    logic [23:0] solid;
  } cfg_t;

  localparam logic [23:0] BAR_EXP [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic cfg_t sample_cfg();
    cfg_t c;
    c.hs_s = int'(tHS_START); c.hs_e = int'(tHS_END);
    c.ha_s = int'(tHACT_START); c.ha_e = int'(tHACT_END); c.h_end = int'(tH_END);
    c.vs_s = int'(tVS_START); c.vs_e = int'(tVS_END);
    c.va_s = int'(tVACT_START); c.va_e = int'(tVACT_END); c.v_end = int'(tV_END);
    c.mode = int'(mode); c.chk = int'(chk_shift); c.bar = int'(bar_shift);
    c.solid = solid_rgb;
    return c;
  endfunction

  function automatic logic [23:0] grey(input int c);
    logic [7:0] b;
    b = 8'(c % 256);
    return {b, b, b};
  endfunction

  function automatic logic [23:0] pattern(input cfg_t c, input int x, input int y, input int frame);
    case (c.mode)
      1: return grey(x);
      2: return BAR_EXP[(x >> c.bar) % 8];
      3: return ((((x >> c.chk) ^ (y >> c.chk)) % 2) != 0) ? 24'hFFFFFF : 24'h000000;
      4: return grey(x + frame);
      default: return c.solid;
    endcase
  endfunction

  cfg_t        m_cfg;
  bit          m_started = 0;
  int          m_pos = 0, m_frame = 0;
  int          mw, mh, mv;
  bit          mact;
  logic        e_hs = 0, e_vs = 0, e_vld = 0, e_sof = 0;
  logic [23:0] e_rgb = '0;
  logic [7:0]  e_fc = '0;

  // Position is derived from the count of enabled cycles within the frame.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      e_hs = 0; e_vs = 0; e_vld = 0; e_sof = 0; e_rgb = '0; e_fc = '0;
      m_started = 0; m_pos = 0; m_frame = 0;
    end else if (en) begin
      if (!m_started) begin
        m_cfg = sample_cfg();
        m_started = 1;
      end
      mw = m_cfg.h_end + 1;
      mh = m_pos % mw;
      mv = m_pos / mw;
      e_hs  = (mh >= m_cfg.hs_s) && (mh < m_cfg.hs_e);
      e_vs  = (mv >= m_cfg.vs_s) && (mv < m_cfg.vs_e);
      mact  = (mh >= m_cfg.ha_s) && (mh < m_cfg.ha_e) && (mv >= m_cfg.va_s) && (mv < m_cfg.va_e);
      e_vld = mact;
      e_sof = (m_pos == 0);
      e_rgb = mact ? pattern(m_cfg, mh - m_cfg.ha_s, mv - m_cfg.va_s, m_frame) : 24'h0;
      if (m_pos == mw * (m_cfg.v_end + 1) - 1) begin
        m_pos = 0;
        m_frame = (m_frame + 1) % 256;
        m_cfg = sample_cfg();
      end else begin
        m_pos++;
      end
      e_fc = 8'(m_frame);
    end else begin
      e_vld = 0; e_sof = 0; e_rgb = '0;
    end
  end

  initial forever begin
    @(negedge clk);
    n_tests++;
    if ({vid.hs_q, vid.vs_q, vid.vld_q, vid.sof_q, vid.rgb, vid.frame_cnt_q} !==
        {e_hs, e_vs, e_vld, e_sof, e_rgb, e_fc}) begin
      n_fail++;
      $display("FAIL cycle_cmp @%0t: got hs=%b vs=%b vld=%b sof=%b rgb=%h fc=%0d, expected hs=%b vs=%b vld=%b sof=%b rgb=%h fc=%0d",
               $time, vid.hs_q, vid.vs_q, vid.vld_q, vid.sof_q, vid.rgb, vid.frame_cnt_q,
               e_hs, e_vs, e_vld, e_sof, e_rgb, e_fc);
    end
  end

  // ---------------- directed checks ----------------
  logic [23:0] px_buf [16];

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_sof();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!vid.sof_q && k < 2000);
    check("sof_seen", vid.sof_q, 1);
  endtask

  task automatic capture_line(output int len);
    int k;
    k = 0;
    while (!vid.vld_q && k < 500) begin
      @(negedge clk);
      k++;
    end
    len = 0;
    while (vid.vld_q && len < 16) begin
      px_buf[len] = vid.rgb;
      len++;
      @(negedge clk);
    end
  endtask

  task automatic measure_frame(input int pause_at, input int pause_len,
                               output int hs_cnt, output int vld_cnt, output int period);
    wait_sof();
    hs_cnt = 0; vld_cnt = 0; period = 0;
    do begin
      hs_cnt  += int'(vid.hs_q);
      vld_cnt += int'(vid.vld_q);
      period++;
      if (period == pause_at) en = 1'b0;
      if (period == pause_at + pause_len) en = 1'b1;
      @(negedge clk);
    end while (!vid.sof_q && period < 2000);
  endtask

  int hs_c, vld_c, per, len, k;

  initial begin
    mode = 3'd0; solid_rgb = 24'h123456; chk_shift = 4'd0; bar_shift = 4'd0;
    tH_END = 12'd15; tHS_START = 12'd2; tHS_END = 12'd4; tHACT_START = 12'd6; tHACT_END = 12'd14;
    tV_END = 12'd5; tVS_START = 12'd0; tVS_END = 12'd1; tVACT_START = 12'd2; tVACT_END = 12'd5;
    #2 rst_n = 1'b0;

    @(negedge clk);
    check("rst_hs", vid.hs_q, 0);
    check("rst_vs", vid.vs_q, 0);
    check("rst_vld", vid.vld_q, 0);
    check("rst_sof", vid.sof_q, 0);
    check("rst_rgb", vid.rgb, 0);
    check("rst_fc", vid.frame_cnt_q, 0);
    @(negedge clk) rst_n = 1'b1;

    @(posedge clk); #1 en = 1'b1;
    @(negedge clk);
    check("sof_before_first_edge", vid.sof_q, 0);
    @(negedge clk);
    check("sof_first", vid.sof_q, 1);
    check("vs_first_line", vid.vs_q, 1);
    check("hs_first_pixel", vid.hs_q, 0);

    // Basic timing, SOLID
    measure_frame(-1, 0, hs_c, vld_c, per);
    check("t1_period", per, 96);
    check("t1_hs_cycles", hs_c, 12);
    check("t1_vld_cycles", vld_c, 24);

    // HRAMP
    mode = 3'd1;
    wait_sof();
    capture_line(len);
    check("hramp_len", len, 8);
    for (int i = 0; i < 8; i++) check($sformatf("hramp_px%0d", i), px_buf[i], i * 24'h010101);
    check("hramp_after_line_rgb", vid.rgb, 0);

    // BARS, width 1
    mode = 3'd2; bar_shift = 4'd0;
    wait_sof();
    capture_line(len);
    check("bars_px0_white", px_buf[0], 24'hFFFFFF);
    check("bars_px1_yellow", px_buf[1], 24'hFFFF00);
    check("bars_px2_cyan", px_buf[2], 24'h00FFFF);
    check("bars_px3_green", px_buf[3], 24'h00FF00);
    check("bars_px4_magenta", px_buf[4], 24'hFF00FF);
    check("bars_px5_red", px_buf[5], 24'hFF0000);
    check("bars_px6_blue", px_buf[6], 24'h0000FF);
    check("bars_px7_black", px_buf[7], 24'h000000);

    // Mid-frame config change only lands at the next frame
    mode = 3'd0;
    wait_sof();
    mode = 3'd3; tHACT_END = 12'd10; chk_shift = 4'd0;
    capture_line(len);
    check("midchg_cur_len", len, 8);
    check("midchg_cur_px0", px_buf[0], 24'h123456);
    check("midchg_cur_px7", px_buf[7], 24'h123456);
    measure_frame(-1, 0, hs_c, vld_c, per);
    check("midchg_next_vld", vld_c, 12);
    check("midchg_next_period", per, 96);
    capture_line(len);
    check("chk_len", len, 4);
    check("chk_px0", px_buf[0], 24'h000000);
    check("chk_px1", px_buf[1], 24'hFFFFFF);
    check("chk_px2", px_buf[2], 24'h000000);
    check("chk_px3", px_buf[3], 24'hFFFFFF);

    // en low for 10 cycles mid-line
    measure_frame(40, 10, hs_c, vld_c, per);
    check("pause_period", per, 106);
    check("pause_vld", vld_c, 12);
    check("pause_hs", hs_c, 12);

    // Async reset mid-frame
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("arst_hs", vid.hs_q, 0);
    check("arst_vs", vid.vs_q, 0);
    check("arst_vld", vid.vld_q, 0);
    check("arst_sof", vid.sof_q, 0);
    check("arst_rgb", vid.rgb, 0);
    check("arst_fc", vid.frame_cnt_q, 0);
    mode = 3'd4; tHACT_END = 12'd14;
    @(negedge clk) rst_n = 1'b1;

    // MOVING across three frames
    for (int f = 0; f < 3; f++) begin
      wait_sof();
      check($sformatf("moving_fc%0d", f), vid.frame_cnt_q, f);
      capture_line(len);
      check($sformatf("moving_len%0d", f), len, 8);
      check($sformatf("moving_px0_f%0d", f), px_buf[0], f * 24'h010101);
    end

    // Short frames to reach the frame counter wrap
    tH_END = 12'd3; tHS_START = 12'd0; tHS_END = 12'd1; tHACT_START = 12'd0; tHACT_END = 12'd2;
    tV_END = 12'd1; tVS_START = 12'd0; tVS_END = 12'd1; tVACT_START = 12'd0; tVACT_END = 12'd1;
    k = 0;
    while (vid.frame_cnt_q != 8'd255 && k < 6000) begin
      @(negedge clk);
      k++;
    end
    check("fc_reach_255", vid.frame_cnt_q, 255);
    wait_sof();
    check("fc_frame255_sof", vid.frame_cnt_q, 255);
    wait_sof();
    check("fc_wrap_0", vid.frame_cnt_q, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
